aura_mixer: RTL



---
 rtl/aura_pkg.sv | 32 +++
 rtl/aura_mix_sat.sv | 32 +++
 rtl/aura_mixer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/aura_pkg.sv
// Shared constants and width helpers for the AURA stereo mixer.
package aura_pkg;

    localparam logic [4:0] AddrStatus = 5'h1E;
    localparam logic [4:0] AddrCtrl   = 5'h1F;

    localparam int unsigned StatusClipL   = 0;
    localparam int unsigned StatusClipR   = 1;
    localparam int unsigned StatusOverrun = 2;

    localparam int unsigned CtrlMute = 0;
    localparam int unsigned CtrlMono = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned pow;
        res = 0;
        pow = 1;
        while (pow < value) begin
            pow = pow << 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Sum of NCHAN full-scale products can never exceed this width.
    function automatic int unsigned acc_width(input int unsigned sw, input int unsigned gw,
                                              input int unsigned nchan);
        return sw + gw + 1 + clog2(nchan);
    endfunction

endpackage

// File: rtl/aura_mix_sat.sv
// Scales a mix accumulator back to sample range (floor shift) and saturates it.
module aura_mix_sat
    import aura_pkg::*;
#(
    parameter int unsigned AW = 26,
    parameter int unsigned SW = 16,
    parameter int unsigned GW = 8
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [SW-1:0] sat_o,
    output logic                 clip_o
);

    logic signed [AW-1:0] shifted;
    logic [AW-SW:0]       hi;

    assign shifted = acc_i >>> (GW - 1);
    assign hi      = shifted[AW-1:SW-1];

    // In range exactly when every bit above the sample MSB repeats the sign.
    always_comb begin
        clip_o = !((hi == '0) || (hi == '1));
        if (!clip_o) begin
            sat_o = shifted[SW-1:0];
        end else if (shifted[AW-1]) begin
            sat_o = {1'b1, {(SW-1){1'b0}}};
        end else begin
            sat_o = {1'b0, {(SW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/aura_mixer.sv
// N-channel stereo mixer: snapshot on tick, serial MAC over channels, scale/saturate, output.
module aura_mixer
    import aura_pkg::*;
#(
    parameter int unsigned   NCHAN      = 2,
    parameter int unsigned   SW         = 16,
    parameter int unsigned   GW         = 8,
    parameter logic [GW-1:0] RESET_GAIN = 8'h40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_i,
    input  logic [NCHAN*SW-1:0] l_chan_i,
    input  logic [NCHAN*SW-1:0] r_chan_i,
    output logic [SW-1:0]       l_chan_o,
    output logic [SW-1:0]       r_chan_o,
    output logic                valid_o,
    output logic                busy_o,
    input  logic [4:0]          reg_addr_i,
    input  logic                reg_wr_i,
    input  logic                reg_rd_i,
    input  logic [7:0]          reg_wdata_i,
    output logic [7:0]          reg_rdata_o
);

    localparam int unsigned AW   = acc_width(SW, GW, NCHAN);
    localparam int unsigned PW   = SW + GW + 1;
    localparam int unsigned SW1  = SW + 1;
    localparam int unsigned IdxW = (clog2(NCHAN) > 0) ? clog2(NCHAN) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StSat  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IdxW-1:0]      idx_q;
    logic signed [AW-1:0] acc_l_q, acc_r_q;
    logic signed [SW-1:0] snap_l_q [NCHAN];
    logic signed [SW-1:0] snap_r_q [NCHAN];
    logic [GW-1:0]        snap_gl_q [NCHAN];
    logic [GW-1:0]        snap_gr_q [NCHAN];
    logic [GW-1:0]        gain_l_q [NCHAN];
    logic [GW-1:0]        gain_r_q [NCHAN];
    logic [2:0]           status_q, status_d;
    logic [1:0]           ctrl_q;
    logic [7:0]           rdata;

    logic signed [PW-1:0]  prod_l, prod_r;
    logic signed [SW-1:0]  sat_l, sat_r, out_l, out_r;
    logic signed [SW1-1:0] mono_sum;
    logic                  clip_l, clip_r;

    assign busy_o = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick_i) state_d = StAcc;
            StAcc:   if (idx_q == IdxW'(NCHAN - 1)) state_d = StSat;
            StSat:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gain is zero-extended so the product stays signed on the sample side only.
    assign prod_l = PW'(snap_l_q[idx_q]) * PW'($signed({1'b0, snap_gl_q[idx_q]}));
    assign prod_r = PW'(snap_r_q[idx_q]) * PW'($signed({1'b0, snap_gr_q[idx_q]}));

    aura_mix_sat #(.AW(AW), .SW(SW), .GW(GW)) u_sat_l (
        .acc_i  (acc_l_q),
        .sat_o  (sat_l),
        .clip_o (clip_l)
    );

    aura_mix_sat #(.AW(AW), .SW(SW), .GW(GW)) u_sat_r (
        .acc_i  (acc_r_q),
        .sat_o  (sat_r),
        .clip_o (clip_r)
    );

    assign mono_sum = SW1'(sat_l) + SW1'(sat_r);

    always_comb begin
        out_l = sat_l;
        out_r = sat_r;
        if (ctrl_q[CtrlMute]) begin
            out_l = '0;
            out_r = '0;
        end else if (ctrl_q[CtrlMono]) begin
            out_l = mono_sum[SW:1];
            out_r = mono_sum[SW:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            l_chan_o <= '0;
            r_chan_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    acc_l_q <= '0;
                    acc_r_q <= '0;
                    idx_q   <= '0;
                end
                StAcc: begin
                    acc_l_q <= acc_l_q + AW'(prod_l);
                    acc_r_q <= acc_r_q + AW'(prod_r);
                    idx_q   <= idx_q + IdxW'(1);
                end
                StSat: begin
                    l_chan_o <= out_l;
                    r_chan_o <= out_r;
                    valid_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StIdle && tick_i) begin
            for (int k = 0; k < NCHAN; k++) begin
                snap_l_q[k]  <= l_chan_i[k*SW +: SW];
                snap_r_q[k]  <= r_chan_i[k*SW +: SW];
                snap_gl_q[k] <= gain_l_q[k];
                snap_gr_q[k] <= gain_r_q[k];
            end
        end
    end

    // Set events win over a coincident write-1-clear.
    always_comb begin
        status_d = status_q;
        if (reg_wr_i && reg_addr_i == AddrStatus) begin
            status_d = status_q & ~reg_wdata_i[2:0];
        end
        if (state_q == StSat && clip_l) status_d[StatusClipL] = 1'b1;
        if (state_q == StSat && clip_r) status_d[StatusClipR] = 1'b1;
        if (tick_i && state_q != StIdle) status_d[StatusOverrun] = 1'b1;
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (reg_addr_i == 5'(2 * k)) rdata = 8'(gain_l_q[k]);
            if (reg_addr_i == 5'(2 * k + 1)) rdata = 8'(gain_r_q[k]);
        end
        if (reg_addr_i == AddrStatus) rdata = {5'b0, status_q};
        if (reg_addr_i == AddrCtrl) rdata = {6'b0, ctrl_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCHAN; k++) begin
                gain_l_q[k] <= RESET_GAIN;
                gain_r_q[k] <= RESET_GAIN;
            end
            status_q    <= '0;
            ctrl_q      <= '0;
            reg_rdata_o <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (reg_wr_i && reg_addr_i == 5'(2 * k)) gain_l_q[k] <= reg_wdata_i[GW-1:0];
                if (reg_wr_i && reg_addr_i == 5'(2 * k + 1)) gain_r_q[k] <= reg_wdata_i[GW-1:0];
            end
            if (reg_wr_i && reg_addr_i == AddrCtrl) ctrl_q <= reg_wdata_i[1:0];
            status_q <= status_d;
            if (reg_rd_i) reg_rdata_o <= rdata;
        end
    end

endmodule
